// File: rtl/keycalc_pkg.sv
// Shared state/op types and raw keypad codes for keypad_bcd_calc.
// The KEYCALC_SUB_EN build macro is consumed by keypad_bcd_calc.sv.
package keycalc_pkg;

  typedef enum logic [1:0] {
    StA    = 2'd0,
    StB    = 2'd1,
    StConv = 2'd2,
    StShow = 2'd3
  } state_e;

  typedef enum logic {
    OpAdd = 1'b0,
    OpSub = 1'b1
  } op_e;

  localparam logic [3:0] KEY_NONE = 4'hF;
  localparam logic [3:0] KEY_ADD  = 4'hA;
  localparam logic [3:0] KEY_SUB  = 4'hB;
  localparam logic [3:0] KEY_CLR  = 4'hC;
  localparam logic [3:0] KEY_EQ   = 4'hE;

  function automatic logic is_digit(input logic [3:0] k);
    return k <= 4'd9;
  endfunction

endpackage

// File: rtl/bcd_dd_serial.sv
// Bit-serial double-dabble: one add-3-then-shift step per cycle, RW cycles per conversion.
module bcd_dd_serial #(
  parameter int unsigned RW = 11,
  parameter int unsigned ND = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic [RW-1:0]   bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd
);

  localparam int unsigned CW = $clog2(RW + 1);

  logic [RW-1:0]   bin_q;
  logic [4*ND-1:0] bcd_q;
  logic [4*ND-1:0] bcd_adj;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;

  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < int'(ND); i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || abort) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        bin_q  <= bin;
        bcd_q  <= '0;
        cnt_q  <= '0;
        busy_q <= 1'b1;
      end else if (busy_q) begin
        {bcd_q, bin_q} <= {bcd_adj[4*ND-2:0], bin_q, 1'b0};
        cnt_q          <= cnt_q + CW'(1);
        if (cnt_q == CW'(RW - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign bcd  = bcd_q;

endmodule

// File: rtl/keypad_bcd_calc.sv
// Keypad calculator: two decimal operands, add (subtract with KEYCALC_SUB_EN), BCD result.
// Define KEYCALC_SUB_EN to build the subtract key and the result sign.
module keypad_bcd_calc
  import keycalc_pkg::*;
#(
  parameter int unsigned DIGITS = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [3:0]              sample,
  output logic [4*(DIGITS+1)-1:0] result_bcd,
  output logic                    result_neg,
  output logic                    result_valid,
  output logic                    busy,
  output logic                    key_err,
  output logic [3:0]              debug
);

  localparam int unsigned W     = $clog2(10 ** DIGITS);
  localparam int unsigned RW    = W + 1;
  localparam int unsigned ND    = DIGITS + 1;
  localparam int unsigned OpMax = 10 ** DIGITS - 1;
  localparam int unsigned CntW  = $clog2(DIGITS + 1);
`ifdef KEYCALC_SUB_EN
  localparam bit SubEn = 1'b1;
`else
  localparam bit SubEn = 1'b0;
`endif

  state_e          state_q;
  op_e             op_q;
  logic [3:0]      sample_q;
  logic [W-1:0]    a_q, b_q, cur, digit_val;
  logic [CntW-1:0] cnt_q;
  logic [RW-1:0]   r_q, r_calc;
  logic            neg_q, neg_calc;
  logic [4*ND-1:0] result_bcd_q, conv_bcd;
  logic            result_neg_q, result_valid_q, busy_q, key_err_q;
  logic            evt, clr, is_op, start_conv, conv_busy, conv_done;

  assign evt        = (sample != sample_q) && (sample != KEY_NONE);
  assign clr        = evt && (sample == KEY_CLR);
  assign is_op      = (sample == KEY_ADD) || (SubEn && (sample == KEY_SUB));
  assign start_conv = evt && (sample == KEY_EQ) && (state_q == StB);
  assign cur        = (state_q == StB) ? b_q : a_q;
  assign digit_val  = cur * W'(10) + W'(sample);

  always_comb begin
    r_calc   = '0;
    neg_calc = 1'b0;
    if (op_q == OpAdd) begin
      r_calc = RW'(a_q) + RW'(b_q);
    end
`ifdef KEYCALC_SUB_EN
    else if (a_q >= b_q) begin
      r_calc = RW'(a_q - b_q);
    end else begin
      r_calc   = RW'(b_q - a_q);
      neg_calc = 1'b1;
    end
`endif
  end

  bcd_dd_serial #(
    .RW(RW),
    .ND(ND)
  ) u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start_conv),
    .abort(clr),
    .bin  (r_calc),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= StA;
      op_q           <= OpAdd;
      sample_q       <= KEY_NONE;
      a_q            <= '0;
      b_q            <= '0;
      cnt_q          <= '0;
      r_q            <= '0;
      neg_q          <= 1'b0;
      result_bcd_q   <= '0;
      result_neg_q   <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      key_err_q      <= 1'b0;
    end else begin
      sample_q  <= sample;
      key_err_q <= 1'b0;
      if (clr) begin
        state_q        <= StA;
        op_q           <= OpAdd;
        a_q            <= '0;
        b_q            <= '0;
        cnt_q          <= '0;
        r_q            <= '0;
        neg_q          <= 1'b0;
        result_bcd_q   <= '0;
        result_neg_q   <= 1'b0;
        result_valid_q <= 1'b0;
        busy_q         <= 1'b0;
      end else begin
        unique case (state_q)
          StA, StB: begin
            if (evt) begin
              if (is_digit(sample)) begin
                if (cnt_q < CntW'(DIGITS)) begin
                  if (state_q == StA) a_q <= digit_val;
                  else                b_q <= digit_val;
                  cnt_q <= cnt_q + CntW'(1);
                end else begin
                  key_err_q <= 1'b1;
                end
              end else if (is_op) begin
                op_q <= (SubEn && (sample == KEY_SUB)) ? OpSub : OpAdd;
                if (state_q == StA) begin
                  state_q <= StB;
                  cnt_q   <= '0;
                end
              end else if (start_conv) begin
                r_q     <= r_calc;
                neg_q   <= neg_calc;
                state_q <= StConv;
              end else begin
                key_err_q <= 1'b1;
              end
            end
          end
          StConv: begin
            // Delayed copy of the converter's busy lines up with the result latch edge.
            busy_q <= conv_busy;
            if (evt) key_err_q <= 1'b1;
            if (conv_done) begin
              result_bcd_q   <= conv_bcd;
              result_neg_q   <= neg_q;
              result_valid_q <= 1'b1;
              state_q        <= StShow;
            end
          end
          StShow: begin
            if (evt) begin
              if (is_digit(sample)) begin
                a_q            <= W'(sample);
                b_q            <= '0;
                cnt_q          <= CntW'(1);
                result_bcd_q   <= '0;
                result_neg_q   <= 1'b0;
                result_valid_q <= 1'b0;
                state_q        <= StA;
              end else if (is_op) begin
                if (!neg_q && (r_q <= RW'(OpMax))) begin
                  a_q            <= r_q[W-1:0];
                  b_q            <= '0;
                  cnt_q          <= '0;
                  op_q           <= (SubEn && (sample == KEY_SUB)) ? OpSub : OpAdd;
                  result_bcd_q   <= '0;
                  result_neg_q   <= 1'b0;
                  result_valid_q <= 1'b0;
                  state_q        <= StB;
                end else begin
                  key_err_q <= 1'b1;
                end
              end else if (sample != KEY_EQ) begin
                key_err_q <= 1'b1;
              end
            end
          end
          default: state_q <= StA;
        endcase
      end
    end
  end

  assign result_bcd   = result_bcd_q;
  assign result_neg   = SubEn & result_neg_q;
  assign result_valid = result_valid_q;
  assign busy         = busy_q;
  assign key_err      = key_err_q;
  assign debug        = ~(4'b0001 << state_q);

endmodule

// File: tb/tb_keypad_bcd_calc.sv
// Bench for keypad_bcd_calc (DIGITS=3): directed vectors, corner sequences, and a
// cycle-by-cycle decimal reference model checked against random keypad traffic.
module tb_keypad_bcd_calc;

  localparam int DIGITS = 3;
  localparam int ND     = DIGITS + 1;
  localparam int RW     = 11;
`ifdef KEYCALC_SUB_EN
  localparam bit SUB = 1'b1;
`else
  localparam bit SUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  sample = 4'hF;
  logic [15:0] result_bcd;
  logic        result_neg, result_valid, busy, key_err;
  logic [3:0]  debug;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keypad_bcd_calc #(.DIGITS(DIGITS)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample      (sample),
    .result_bcd  (result_bcd),
    .result_neg  (result_neg),
    .result_valid(result_valid),
    .busy        (busy),
    .key_err     (key_err),
    .debug       (debug)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (decimal arithmetic, per-edge) ----------------
  int          mst, ma, mb, mcnt, mop, mres, mk;
  bit          mneg;
  logic [3:0]  m_sq;
  logic [15:0] e_bcd;
  bit          e_neg, e_valid, e_busy, e_err;

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    r = '0;
    x = v;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic m_clear();
    mst = 0; ma = 0; mb = 0; mcnt = 0; mop = 0; mres = 0; mneg = 0; mk = 0;
    e_bcd = '0; e_neg = 0; e_valid = 0; e_busy = 0; e_err = 0;
  endtask

  task automatic m_step(input logic [3:0] s, input logic rn);
    bit ev;
    if (!rn) begin
      m_clear();
      m_sq = 4'hF;
      return;
    end
    ev    = (s != m_sq) && (s != 4'hF);
    m_sq  = s;
    e_err = 0;
    if (ev && s == 4'hC) begin
      m_clear();
      return;
    end
    case (mst)
      0, 1: if (ev) begin
        if (s <= 4'd9) begin
          if (mcnt < DIGITS) begin
            if (mst == 0) ma = ma * 10 + int'(s);
            else          mb = mb * 10 + int'(s);
            mcnt++;
          end else e_err = 1;
        end else if (s == 4'hA || (SUB && s == 4'hB)) begin
          mop = (s == 4'hB) ? 1 : 0;
          if (mst == 0) begin mst = 1; mcnt = 0; end
        end else if (s == 4'hE && mst == 1) begin
          if (mop == 0)     begin mres = ma + mb; mneg = 0; end
          else if (ma >= mb) begin mres = ma - mb; mneg = 0; end
          else              begin mres = mb - ma; mneg = 1; end
          mst = 2;
          mk  = 0;
        end else e_err = 1;
      end
      2: begin
        if (ev) e_err = 1;
        mk++;
        if (mk <= RW) e_busy = 1;
        else begin
          e_busy = 0; e_valid = 1; e_bcd = to_bcd(mres); e_neg = mneg; mst = 3;
        end
      end
      default: if (ev) begin
        if (s <= 4'd9) begin
          ma = int'(s); mb = 0; mcnt = 1; mst = 0;
          e_valid = 0; e_bcd = '0; e_neg = 0;
        end else if (s == 4'hA || (SUB && s == 4'hB)) begin
          if (!mneg && mres <= 999) begin
            ma = mres; mb = 0; mcnt = 0; mop = (s == 4'hB) ? 1 : 0; mst = 1;
            e_valid = 0; e_bcd = '0; e_neg = 0;
          end else e_err = 1;
        end else if (s != 4'hE) e_err = 1;
      end
    endcase
  endtask

  function automatic logic [23:0] m_obs();
    logic [3:0] dbg;
    dbg      = 4'b1111;
    dbg[mst] = 1'b0;
    return {e_bcd, e_neg, e_valid, e_busy, e_err, dbg};
  endfunction

  initial begin
    m_clear();
    m_sq = 4'hF;
    forever begin
      @(posedge clk);
      m_step(sample, rst_n);
      #1;
      chk("model {bcd,neg,valid,busy,err,debug}",
          {40'h0, result_bcd, result_neg, result_valid, busy, key_err, debug}, {40'h0, m_obs()});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic press(input logic [3:0] k);
    @(negedge clk) sample = k;
    @(negedge clk) sample = 4'hF;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 40 && !result_valid; i++) @(negedge clk);
    chk({name, " valid-timeout"}, result_valid, 1);
  endtask

  typedef struct {
    logic [31:0] keys;
    int          n;
    logic [15:0] bcd;
    logic        neg;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{32'h123A456E, 8, 16'h0579, 1'b0};
    vecs[1] = '{32'h999A999E, 8, 16'h1998, 1'b0};
    vecs[2] = '{32'h0A0E0000, 4, 16'h0000, 1'b0};
    vecs[3] = '{32'hA7E00000, 3, 16'h0007, 1'b0};
    vecs[4] = '{32'h1234A1E0, 7, 16'h0124, 1'b0};
    vecs[5] = '{32'h8A8AE000, 5, 16'h0016, 1'b0};
    vecs[7] = '{32'h7D7A1E00, 6, 16'h0078, 1'b0};
`ifdef KEYCALC_SUB_EN
    vecs[6] = '{32'h12B345E0, 7, 16'h0333, 1'b1};
`else
    vecs[6] = '{32'h12BA345E, 8, 16'h0357, 1'b0};
`endif

    repeat (3) @(negedge clk);
    chk("reset outputs", {result_bcd, result_neg, result_valid, busy, key_err, debug},
        {16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b1110});
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven full entries
    for (int v = 0; v < 8; v++) begin
      press(4'hC);
      for (int i = 0; i < vecs[v].n; i++) press(vecs[v].keys[31-4*i -: 4]);
      wait_valid($sformatf("vec%0d", v));
      chk($sformatf("vec%0d bcd", v), result_bcd, vecs[v].bcd);
      chk($sformatf("vec%0d neg", v), result_neg, vecs[v].neg);
      chk($sformatf("vec%0d debug", v), debug, 4'b0111);
    end

    // Exact latency from the E edge
    press(4'hC);
    press(4'h1); press(4'h2); press(4'h3); press(4'hA); press(4'h4); press(4'h5); press(4'h6);
    @(negedge clk) sample = 4'hE;
    for (int k = 0; k <= RW + 1; k++) begin
      @(negedge clk);
      sample = 4'hF;
      chk($sformatf("latency edge%0d {busy,valid}", k), {busy, result_valid},
          {(k >= 1 && k <= RW), (k == RW + 1)});
    end
    chk("latency bcd", result_bcd, 16'h0579);

    // Fourth digit rejected with a one-cycle key_err
    press(4'hC);
    press(4'h1); press(4'h2); press(4'h3);
    @(negedge clk) sample = 4'h4;
    @(negedge clk) chk("4th digit key_err", key_err, 1);
    sample = 4'hF;
    @(negedge clk) chk("4th digit key_err one cycle", key_err, 0);
    press(4'hA); press(4'h0); press(4'hE);
    wait_valid("4th digit");
    chk("4th digit result", result_bcd, 16'h0123);

    // A held key counts once
    press(4'hC);
    @(negedge clk) sample = 4'h5;
    repeat (10) @(negedge clk);
    sample = 4'hF;
    press(4'hA); press(4'h1); press(4'hE);
    wait_valid("hold");
    chk("hold result", result_bcd, 16'h0006);

    // Chaining from a shown result
    press(4'hC);
    press(4'h5); press(4'hA); press(4'h5); press(4'hE);
    wait_valid("chain first");
    chk("chain first", result_bcd, 16'h0010);
    press(4'hA); press(4'h7); press(4'hE);
    wait_valid("chain second");
    chk("chain second", result_bcd, 16'h0017);

    // Chain refused when the result does not fit an operand
    press(4'hC);
    press(4'h9); press(4'h9); press(4'h9); press(4'hA);
    press(4'h9); press(4'h9); press(4'h9); press(4'hE);
    wait_valid("overflow");
    @(negedge clk) sample = 4'hA;
    @(negedge clk) chk("overflow chain key_err", key_err, 1);
    sample = 4'hF;
    chk("overflow chain held", {result_valid, debug, result_bcd}, {1'b1, 4'b0111, 16'h1998});

    // Clear during conversion
    press(4'hC);
    press(4'h1); press(4'hA); press(4'h1);
    @(negedge clk) sample = 4'hE;
    @(negedge clk) sample = 4'hF;
    repeat (3) @(negedge clk);
    chk("conv busy before clear", busy, 1);
    press(4'hC);
    chk("clear in conv", {debug, result_valid, result_bcd, busy}, {4'b1110, 1'b0, 16'h0, 1'b0});
    repeat (15) @(negedge clk);
    chk("clear in conv stays aborted", {debug, result_valid}, {4'b1110, 1'b0});

    // Reset during conversion
    press(4'h2); press(4'hA); press(4'h2);
    @(negedge clk) sample = 4'hE;
    @(negedge clk) sample = 4'hF;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    chk("reset in conv", {debug, result_valid, result_bcd, busy}, {4'b1110, 1'b0, 16'h0, 1'b0});
    repeat (15) @(negedge clk);
    chk("reset in conv stays aborted", {debug, result_valid}, {4'b1110, 1'b0});

    // Random keypad traffic, checked by the model every edge
    for (int it = 0; it < 2000; it++) begin
      int r;
      logic [3:0] k;
      r = $urandom_range(0, 99);
      if      (r < 58) k = 4'($urandom_range(0, 9));
      else if (r < 68) k = 4'hA;
      else if (r < 74) k = 4'hB;
      else if (r < 85) k = 4'hE;
      else if (r < 88) k = 4'hC;
      else if (r < 91) k = 4'hD;
      else             k = 4'hF;
      @(negedge clk) sample = k;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if ($urandom_range(0, 9) < 7) begin
        @(negedge clk) sample = 4'hF;
        if (k == 4'hE) repeat ($urandom_range(0, 15)) @(negedge clk);
      end
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
      end
    end
    @(negedge clk) sample = 4'hF;
    repeat (20) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
